controle_autenticacao: RTL and testbench



---
 rtl/controle_autenticacao_if.sv | 28 ++
 rtl/controle_autenticacao.sv | 161 ++++++++++++++++
 tb/tb_controle_autenticacao.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/controle_autenticacao_if.sv
// Panel/comparator bundle for the authentication controller: request inputs,
// comparator drive and result, and status outputs.
interface controle_autenticacao_if;
  logic       iniciar;
  logic [2:0] usuario;
  logic [2:0] senha;
  logic [2:0] cmp_usuario;
  logic [2:0] cmp_senha;
  logic [2:0] cmp_aut;
  logic       ocupado;
  logic       acesso_liberado;
  logic [1:0] nivel;
  logic       negado;
  logic       bloqueado;
  logic [2:0] tentativas;

  modport master (
    output iniciar, usuario, senha, cmp_aut,
    input  cmp_usuario, cmp_senha, ocupado, acesso_liberado, nivel,
           negado, bloqueado, tentativas
  );

  modport slave (
    input  iniciar, usuario, senha, cmp_aut,
    output cmp_usuario, cmp_senha, ocupado, acesso_liberado, nivel,
           negado, bloqueado, tentativas
  );
endinterface

// File: rtl/controle_autenticacao.sv
// Sequencer around the combinational authentication comparator: captures a
// request, grants access for a fixed window, and locks out after repeated failures.
//
// state    | meaning
// IDLE     | waiting for iniciar
// APLICA   | request held on comparator, one settling cycle
// LIBERADO | access granted, grant timer running
// NEGADO   | failed check, negado pulse
// BLOQUEIO | lockout, lock timer running
module controle_autenticacao #(
  parameter int MAX_TENTATIVAS = 3,
  parameter int GRANT_CICLOS   = 8,
  parameter int LOCK_CICLOS    = 16
) (
  input logic clk,
  input logic rst_n,
  controle_autenticacao_if.slave bus
);

  localparam int T_MAX = ((GRANT_CICLOS > LOCK_CICLOS) ? GRANT_CICLOS : LOCK_CICLOS) - 1;
  localparam int TW    = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);
  localparam logic [TW-1:0] GRANT_INI = TW'(GRANT_CICLOS - 1);
  localparam logic [TW-1:0] LOCK_INI  = TW'(LOCK_CICLOS - 1);
  localparam logic [2:0]    MAX_FALHAS = 3'(MAX_TENTATIVAS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APLICA   = 3'd1,
    LIBERADO = 3'd2,
    NEGADO   = 3'd3,
    BLOQUEIO = 3'd4
  } estado_t;

  estado_t     r_estado;
  logic [TW-1:0] r_timer;
  logic [2:0]  r_cmp_usuario;
  logic [2:0]  r_cmp_senha;
  logic        r_ocupado;
  logic        r_acesso;
  logic [1:0]  r_nivel;
  logic        r_negado;
  logic        r_bloqueado;
  logic [2:0]  r_tentativas;

  logic [1:0]  w_nivel;
  logic [2:0]  w_falhas_prox;

  // Bit 2 has priority, then bit 1, then bit 0.
  always_comb begin
    w_nivel = 2'd0;
    if (bus.cmp_aut[2])      w_nivel = 2'd3;
    else if (bus.cmp_aut[1]) w_nivel = 2'd2;
    else if (bus.cmp_aut[0]) w_nivel = 2'd1;
  end

  assign w_falhas_prox = (r_tentativas >= MAX_FALHAS) ? MAX_FALHAS : r_tentativas + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado      <= IDLE;
      r_timer       <= '0;
      r_cmp_usuario <= 3'd0;
      r_cmp_senha   <= 3'd0;
      r_ocupado     <= 1'b0;
      r_acesso      <= 1'b0;
      r_nivel       <= 2'd0;
      r_negado      <= 1'b0;
      r_bloqueado   <= 1'b0;
      r_tentativas  <= 3'd0;
    end else begin
      case (r_estado)
        IDLE: begin
          if (bus.iniciar) begin
            r_cmp_usuario <= bus.usuario;
            r_cmp_senha   <= bus.senha;
            r_ocupado     <= 1'b1;
            r_estado      <= APLICA;
          end
        end

        APLICA: begin
          if (bus.cmp_aut != 3'd0) begin
            r_nivel      <= w_nivel;
            r_acesso     <= 1'b1;
            r_tentativas <= 3'd0;
            r_timer      <= GRANT_INI;
            r_estado     <= LIBERADO;
          end else begin
            r_negado     <= 1'b1;
            r_tentativas <= w_falhas_prox;
            if (w_falhas_prox == MAX_FALHAS) begin
              r_bloqueado <= 1'b1;
              r_timer     <= LOCK_INI;
              r_estado    <= BLOQUEIO;
            end else begin
              r_estado <= NEGADO;
            end
          end
        end

        LIBERADO: begin
          if (r_timer == '0) begin
            r_acesso      <= 1'b0;
            r_nivel       <= 2'd0;
            r_cmp_usuario <= 3'd0;
            r_cmp_senha   <= 3'd0;
            r_ocupado     <= 1'b0;
            r_estado      <= IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        NEGADO: begin
          r_negado      <= 1'b0;
          r_cmp_usuario <= 3'd0;
          r_cmp_senha   <= 3'd0;
          r_ocupado     <= 1'b0;
          r_estado      <= IDLE;
        end

        BLOQUEIO: begin
          // negado from the failing check overlaps the first lockout cycle.
          r_negado <= 1'b0;
          if (r_timer == '0) begin
            r_bloqueado   <= 1'b0;
            r_tentativas  <= 3'd0;
            r_cmp_usuario <= 3'd0;
            r_cmp_senha   <= 3'd0;
            r_ocupado     <= 1'b0;
            r_estado      <= IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        default: begin
          r_estado      <= IDLE;
          r_timer       <= '0;
          r_cmp_usuario <= 3'd0;
          r_cmp_senha   <= 3'd0;
          r_ocupado     <= 1'b0;
          r_acesso      <= 1'b0;
          r_nivel       <= 2'd0;
          r_negado      <= 1'b0;
          r_bloqueado   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmp_usuario     = r_cmp_usuario;
  assign bus.cmp_senha       = r_cmp_senha;
  assign bus.ocupado         = r_ocupado;
  assign bus.acesso_liberado = r_acesso;
  assign bus.nivel           = r_nivel;
  assign bus.negado          = r_negado;
  assign bus.bloqueado       = r_bloqueado;
  assign bus.tentativas      = r_tentativas;

endmodule

// File: tb/tb_controle_autenticacao.sv
// Directed bench for controle_autenticacao with a small comparator lookup model.
module tb_controle_autenticacao;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  controle_autenticacao_if bus ();

  controle_autenticacao #(
    .MAX_TENTATIVAS(3),
    .GRANT_CICLOS  (8),
    .LOCK_CICLOS   (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: only a few user/password pairs are authorised.
  always_comb begin
    bus.cmp_aut = 3'b000;
    if (bus.cmp_usuario == 3'b101 && bus.cmp_senha == 3'b011) bus.cmp_aut = 3'b100;
    if (bus.cmp_usuario == 3'b010 && bus.cmp_senha == 3'b110) bus.cmp_aut = 3'b011;
    if (bus.cmp_usuario == 3'b001 && bus.cmp_senha == 3'b001) bus.cmp_aut = 3'b001;
  end

  typedef struct {
    logic [2:0] u;
    logic [2:0] s;
    logic       ok;
    logic [1:0] nivel;
    logic [2:0] tent;
  } vec_t;

  vec_t tab[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues a one-cycle request; returns sampled just after the APLICA edge.
  task automatic req(input logic [2:0] u, input logic [2:0] s);
    bus.iniciar = 1'b1;
    bus.usuario = u;
    bus.senha   = s;
    step();
    bus.iniciar = 1'b0;
    chk("cmp_usuario_captured", int'(bus.cmp_usuario), int'(u));
    chk("cmp_senha_captured", int'(bus.cmp_senha), int'(s));
    chk("ocupado_in_aplica", int'(bus.ocupado), 1);
    step();
  endtask

  // Counts consecutive samples with acesso_liberado high, bounded.
  task automatic grant_len(output int n);
    n = 0;
    while (bus.acesso_liberado && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ocupado"}, int'(bus.ocupado), 0);
    chk({tag, "_cmp_usuario"}, int'(bus.cmp_usuario), 0);
    chk({tag, "_cmp_senha"}, int'(bus.cmp_senha), 0);
    chk({tag, "_nivel"}, int'(bus.nivel), 0);
  endtask

  task automatic apply_vec(input vec_t v);
    int n;
    req(v.u, v.s);
    chk("tentativas", int'(bus.tentativas), int'(v.tent));
    if (v.ok) begin
      chk("acesso_liberado", int'(bus.acesso_liberado), 1);
      chk("nivel", int'(bus.nivel), int'(v.nivel));
      chk("negado_on_grant", int'(bus.negado), 0);
      grant_len(n);
      chk("grant_length", n, 8);
      check_idle("after_grant");
    end else begin
      chk("negado_pulse", int'(bus.negado), 1);
      chk("acesso_on_fail", int'(bus.acesso_liberado), 0);
      chk("bloqueado_on_fail", int'(bus.bloqueado), 0);
      step();
      chk("negado_end", int'(bus.negado), 0);
      check_idle("after_fail");
    end
  endtask

  task automatic three_fails();
    vec_t f;
    f.u = 3'b111; f.s = 3'b111; f.ok = 1'b0; f.nivel = 2'd0;
    f.tent = 3'd1; apply_vec(f);
    f.tent = 3'd2; apply_vec(f);
    req(3'b111, 3'b000);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.iniciar = 1'b0;
    bus.usuario = 3'd0;
    bus.senha   = 3'd0;

    tab[0] = '{u: 3'b101, s: 3'b011, ok: 1'b1, nivel: 2'd3, tent: 3'd0};
    tab[1] = '{u: 3'b010, s: 3'b110, ok: 1'b1, nivel: 2'd2, tent: 3'd0};
    tab[2] = '{u: 3'b001, s: 3'b001, ok: 1'b1, nivel: 2'd1, tent: 3'd0};
    tab[3] = '{u: 3'b111, s: 3'b111, ok: 1'b0, nivel: 2'd0, tent: 3'd1};
    tab[4] = '{u: 3'b000, s: 3'b000, ok: 1'b0, nivel: 2'd0, tent: 3'd2};
    tab[5] = '{u: 3'b101, s: 3'b011, ok: 1'b1, nivel: 2'd3, tent: 3'd0};
    tab[6] = '{u: 3'b110, s: 3'b000, ok: 1'b0, nivel: 2'd0, tent: 3'd1};
    tab[7] = '{u: 3'b001, s: 3'b001, ok: 1'b1, nivel: 2'd1, tent: 3'd0};

    #23;
    check_idle("reset");
    chk("reset_acesso", int'(bus.acesso_liberado), 0);
    chk("reset_bloqueado", int'(bus.bloqueado), 0);
    chk("reset_tentativas", int'(bus.tentativas), 0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", int'(bus.ocupado), 0);

    for (int i = 0; i < 8; i++) apply_vec(tab[i]);

    // Lockout: third failure, iniciar ignored during lockout.
    three_fails();
    chk("lock_negado", int'(bus.negado), 1);
    chk("lock_bloqueado", int'(bus.bloqueado), 1);
    chk("lock_tentativas", int'(bus.tentativas), 3);
    n = 0;
    while (bus.bloqueado && n < 100) begin
      if (n == 1) chk("lock_negado_end", int'(bus.negado), 0);
      bus.iniciar = (n < 5);
      bus.usuario = 3'b101;
      bus.senha   = 3'b011;
      n++;
      step();
    end
    bus.iniciar = 1'b0;
    chk("lock_length", n, 16);
    chk("lock_tentativas_clear", int'(bus.tentativas), 0);
    chk("lock_acesso", int'(bus.acesso_liberado), 0);
    check_idle("after_lock");
    step();
    chk("no_queued_after_lock", int'(bus.ocupado), 0);

    // Input changes and iniciar during APLICA/LIBERADO have no effect.
    bus.iniciar = 1'b1;
    bus.usuario = 3'b101;
    bus.senha   = 3'b011;
    step();
    bus.iniciar = 1'b0;
    bus.usuario = 3'b000;
    bus.senha   = 3'b111;
    step();
    chk("hold_acesso", int'(bus.acesso_liberado), 1);
    chk("hold_cmp_usuario_aplica", int'(bus.cmp_usuario), 5);
    bus.iniciar = 1'b1;
    bus.usuario = 3'b010;
    bus.senha   = 3'b110;
    step();
    bus.iniciar = 1'b0;
    chk("hold_cmp_usuario", int'(bus.cmp_usuario), 5);
    chk("hold_cmp_senha", int'(bus.cmp_senha), 3);
    chk("hold_nivel", int'(bus.nivel), 3);
    grant_len(n);
    chk("hold_grant_length", n + 1, 8);
    check_idle("after_hold");
    step();
    chk("no_new_request", int'(bus.ocupado), 0);

    // Asynchronous reset mid-LIBERADO.
    req(3'b010, 3'b110);
    step(); step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_lib_acesso", int'(bus.acesso_liberado), 0);
    check_idle("arst_lib");
    rst_n = 1'b1;
    step();
    chk("arst_lib_idle", int'(bus.ocupado), 0);

    // Asynchronous reset mid-BLOQUEIO loses the failure count.
    three_fails();
    step(); step(); step(); step();
    chk("pre_arst_bloqueado", int'(bus.bloqueado), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_lock_bloqueado", int'(bus.bloqueado), 0);
    chk("arst_lock_tentativas", int'(bus.tentativas), 0);
    chk("arst_lock_negado", int'(bus.negado), 0);
    check_idle("arst_lock");
    rst_n = 1'b1;
    step();
    chk("arst_lock_idle", int'(bus.ocupado), 0);
    apply_vec('{u: 3'b011, s: 3'b011, ok: 1'b0, nivel: 2'd0, tent: 3'd1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
